// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester side and the transmitter side of the shared-UART
//   arbiter into one interface.
//
//   Requester side : Req, ReqData (in to arbiter), Grant, Done (out)
//   Transmitter    : TxEn, TxData, NBits (out of arbiter), TxDone (in)
//   Status         : Busy, Timeout (out of arbiter)
//
//   slave  modport : used by the arbiter itself.
//   master modport : used by whatever drives the requests and models the
//                    transmitter (requesters + UART TX).
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   Req;
  logic [8*N_REQ-1:0] ReqData;
  logic [N_REQ-1:0]   Grant;
  logic [N_REQ-1:0]   Done;
  logic               TxEn;
  logic [7:0]         TxData;
  logic [3:0]         NBits;
  logic               TxDone;
  logic               Busy;
  logic               Timeout;

  modport slave (
    input  Req, ReqData, TxDone,
    output Grant, Done, TxEn, TxData, NBits, Busy, Timeout
  );

  modport master (
    output Req, ReqData, TxDone,
    input  Grant, Done, TxEn, TxData, NBits, Busy, Timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter/sequencer sharing one 8-bit UART transmitter between
//   N_REQ byte sources. The winning byte is latched into TxData and held until
//   the next grant, TxEn is pulsed for STROBE_LEN cycles, and completion is
//   taken from a fresh rising edge of the transmitter's TxDone level. A
//   watchdog (2^TO_W-1 cycles) keeps a stalled transmitter from locking the
//   arbiter.
//
//   Ports:
//     Clk  : system clock
//     Rst  : synchronous active-high reset (shared with the transmitter)
//     bus  : uart_tx_arbiter_if.slave
//              Req/ReqData in, Grant/Done one-hot pulses out,
//              TxEn/TxData/NBits to the transmitter, TxDone from it,
//              Busy (state != IDLE), Timeout (1-cycle watchdog pulse)
//
//   Parameters: N_REQ (2..8), STROBE_LEN (>=2), GAP (idle cycles after
//   TxDone falls), TO_W (watchdog width), NBITS_CFG (driven on NBits).
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int STROBE_LEN = 2,
  parameter int GAP        = 4,
  parameter int TO_W       = 20,
  parameter int NBITS_CFG  = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(N_REQ);

  // The watchdog fires on the cycle whose increment would bring the counter
  // to all-ones, i.e. on the (2^TO_W-1)-th cycle spent waiting.
  localparam logic [TO_W-1:0] CNT_PRE_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] STROBE_CNT   = TO_W'(STROBE_LEN);
  // A GAP of 0 degenerates to a single idle cycle in GAP_WAIT.
  localparam logic [TO_W-1:0] GAP_LAST     = TO_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT_DONE,
    RELEASE,
    GAP_WAIT
  } state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic [PTR_W-1:0]   sel_reg, sel_next;
  logic [7:0]         data_reg, data_next;
  logic [N_REQ-1:0]   grant_reg, grant_next;
  logic [N_REQ-1:0]   done_reg, done_next;
  logic               txen_reg, txen_next;
  logic               tmo_reg, tmo_next;
  logic [TO_W-1:0]    cnt_reg, cnt_next;
  logic               txdone_q_reg;

  logic               txdone_rise;
  logic               expire;

  // Round-robin candidate list: entry gi is requester (ptr + gi) mod N_REQ,
  // so entry 0 has the highest priority.
  logic [PTR_W-1:0]   cand_idx [N_REQ];
  logic [N_REQ-1:0]   cand_req;
  logic [7:0]         req_byte [N_REQ];
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [PTR_W:0] sum;
    assign sum           = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
    assign cand_idx[gi]  = (sum >= (PTR_W+1)'(N_REQ))
                           ? PTR_W'(sum - (PTR_W+1)'(N_REQ))
                           : sum[PTR_W-1:0];
    assign cand_req[gi]  = bus.Req[cand_idx[gi]];
    assign req_byte[gi]  = bus.ReqData[8*gi +: 8];
  end

  // Highest-numbered candidate first so the lowest-numbered set one wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  // Only a fresh rise counts: a TxDone level left high from a previous frame
  // (or raised while still strobing) must not complete the current one.
  assign txdone_rise = bus.TxDone & ~txdone_q_reg;
  assign expire      = (cnt_reg == CNT_PRE_LAST);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    data_next  = data_reg;
    grant_next = '0;
    done_next  = '0;
    txen_next  = 1'b0;
    tmo_next   = 1'b0;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (pick_valid) begin
          sel_next             = pick_idx;
          data_next            = req_byte[pick_idx];
          grant_next[pick_idx] = 1'b1;
          ptr_next             = (pick_idx == PTR_W'(N_REQ - 1))
                                 ? '0 : pick_idx + PTR_W'(1);
          state_next           = STROBE;
        end
      end

      // TxEn is registered, so it appears one cycle after the grant and
      // stays up for exactly STROBE_LEN cycles.
      STROBE: begin
        if (cnt_reg < STROBE_CNT) begin
          txen_next = 1'b1;
          cnt_next  = cnt_reg + TO_W'(1);
        end else begin
          cnt_next   = '0;
          state_next = WAIT_DONE;
        end
      end

      // Completion takes precedence over a simultaneous watchdog expiry.
      WAIT_DONE: begin
        if (txdone_rise) begin
          done_next[sel_reg] = 1'b1;
          cnt_next           = '0;
          state_next         = RELEASE;
        end else if (expire) begin
          tmo_next   = 1'b1;
          cnt_next   = '0;
          state_next = RELEASE;
        end else begin
          cnt_next = cnt_reg + TO_W'(1);
        end
      end

      // The transmitter ignores new strobes while TxDone is high, so wait for
      // it to drop (or give up on the watchdog) before the gap.
      RELEASE: begin
        if (!bus.TxDone) begin
          cnt_next   = '0;
          state_next = GAP_WAIT;
        end else if (expire) begin
          tmo_next   = 1'b1;
          cnt_next   = '0;
          state_next = GAP_WAIT;
        end else begin
          cnt_next = cnt_reg + TO_W'(1);
        end
      end

      GAP_WAIT: begin
        if (cnt_reg >= GAP_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + TO_W'(1);
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      sel_reg      <= '0;
      data_reg     <= '0;
      grant_reg    <= '0;
      done_reg     <= '0;
      txen_reg     <= 1'b0;
      tmo_reg      <= 1'b0;
      cnt_reg      <= '0;
      txdone_q_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      sel_reg      <= sel_next;
      data_reg     <= data_next;
      grant_reg    <= grant_next;
      done_reg     <= done_next;
      txen_reg     <= txen_next;
      tmo_reg      <= tmo_next;
      cnt_reg      <= cnt_next;
      txdone_q_reg <= bus.TxDone;
    end
  end

  assign bus.Grant   = grant_reg;
  assign bus.Done    = done_reg;
  assign bus.TxEn    = txen_reg;
  assign bus.TxData  = data_reg;
  assign bus.NBits   = 4'(NBITS_CFG);
  assign bus.Busy    = (state_reg != IDLE);
  assign bus.Timeout = tmo_reg;

endmodule
